// File: rtl/opm_wrq_pkg.sv
// Shared types for the OPM write queue: queue entry layout, drain FSM
// states and the host address bit that selects the extended registers.
package opm_wrq_pkg;

  typedef struct packed {
    logic       a0;
    logic [7:0] data;
  } wrq_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GAP
  } drain_state_e;

  // Host address bit that selects the queue's own status/control register
  // instead of the OPM.
  localparam int unsigned EXT_SEL_BIT = 1;

  localparam int unsigned ENTRY_W = $bits(wrq_entry_t);

endpackage

// File: rtl/opm_write_queue_if.sv
// Host slave port of the OPM write queue (NORA side). The host drives the
// request/address/data lines and receives read data.
interface opm_write_queue_if;

  logic [4:0] slv_addr_i;
  logic [7:0] slv_datawr_i;
  logic       slv_datawr_valid;
  logic       slv_req_i;
  logic       slv_rwn_i;
  logic [7:0] slv_datard_o;

  modport master (
    output slv_addr_i, slv_datawr_i, slv_datawr_valid, slv_req_i, slv_rwn_i,
    input  slv_datard_o
  );

  modport slave (
    input  slv_addr_i, slv_datawr_i, slv_datawr_valid, slv_req_i, slv_rwn_i,
    output slv_datard_o
  );

endinterface

// File: rtl/opm_wrq_fifo.sv
// Synchronous single-clock FIFO, one write and one read port, show-ahead
// read data. A write while full is accepted only if a read frees a slot
// in the same cycle.
module opm_wrq_fifo #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ok, rd_ok;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign rd_ok     = rd_en_i & ~empty_o;
  assign wr_ok     = wr_en_i & (~full_o | rd_ok);

  // Storage array write.
  // NOTE: the data array has no reset; validity is tracked by the pointers
  // and count, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer and occupancy registers; pointers wrap modulo DEPTH.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Next occupancy from the accepted write/read pair.
  // NOTE: default assignment first so no path leaves count_d unassigned (latch).
  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

endmodule

// File: rtl/opm_write_queue.sv
// OPM write queue: absorbs host register writes for the YM2151 and drains
// them onto the OPM bus, honouring the busy flag and a fixed write spacing.
// Optional status register enabled by defining OPM_WRQ_STATUS_EN.
module opm_write_queue
  import opm_wrq_pkg::*;
#(
  parameter int DEPTH_LOG2    = 4,
  parameter int STROBE_CYCLES = 14,
  parameter int GAP_CYCLES    = 28
) (
  input  logic                clk,
  input  logic                reset,
  opm_write_queue_if.slave    slv,
  output logic                opm_cs_n,
  output logic                opm_wr_n,
  output logic                opm_a0,
  output logic [7:0]          opm_d,
  input  logic [7:0]          opm_status_i
);

  localparam int CNT_W   = DEPTH_LOG2 + 1;
  localparam int TMR_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic             w, w_q, w_rise, ext_sel, ext_wr, push, pop;
  logic             full, empty;
  logic [CNT_W-1:0] count;
  wrq_entry_t       wr_entry, rd_entry;
  drain_state_e     state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             opm_a0_q;
  logic [7:0]       opm_d_q;

  assign w        = slv.slv_req_i & slv.slv_datawr_valid & ~slv.slv_rwn_i;
  assign w_rise   = w & ~w_q;
  assign ext_sel  = slv.slv_addr_i[EXT_SEL_BIT];
  assign push     = w_rise & ~ext_sel;
  assign ext_wr   = w_rise & ext_sel;
  assign wr_entry = '{a0: slv.slv_addr_i[0], data: slv.slv_datawr_i};

  // Access edge detect: one enqueue per host access however long valid lasts.
  always_ff @(posedge clk) begin
    if (reset) w_q <= 1'b0;
    else       w_q <= w;
  end

  opm_wrq_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (rd_entry),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Drain FSM state and phase timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Drain FSM next state: issue only when an entry waits and the OPM is not busy.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (~empty & ~opm_status_i[7]) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (tmr_q == TMR_W'(STROBE_CYCLES - 1)) begin
          state_d = ST_GAP;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Drain FSM outputs: dequeue on the issue transition, strobe while in STROBE.
  always_comb begin
    pop      = (state_q == ST_IDLE) && (state_d == ST_STROBE);
    opm_cs_n = (state_q != ST_STROBE);
    opm_wr_n = (state_q != ST_STROBE);
  end

  // OPM address/data hold registers, loaded as the entry leaves the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      opm_a0_q <= 1'b0;
      opm_d_q  <= 8'h00;
    end else if (pop) begin
      opm_a0_q <= rd_entry.a0;
      opm_d_q  <= rd_entry.data;
    end
  end

  assign opm_a0 = opm_a0_q;
  assign opm_d  = opm_d_q;

`ifdef OPM_WRQ_STATUS_EN
  logic ovf_q;
  logic drop;
  logic unused_bits;

  assign drop        = push & full & ~pop;
  assign unused_bits = ^slv.slv_addr_i[4:2];

  // Sticky overflow flag: set by a dropped enqueue, cleared by an extended write.
  always_ff @(posedge clk) begin
    if (reset)       ovf_q <= 1'b0;
    else if (ext_wr) ovf_q <= 1'b0;
    else if (drop)   ovf_q <= 1'b1;
  end
`else
  logic unused_bits;

  assign unused_bits = ^{slv.slv_addr_i[4:2], count, ext_wr};
`endif

  // Host read mux: OPM status with queue-full in bit7, or the extended register.
  always_comb begin
    if (ext_sel) begin
`ifdef OPM_WRQ_STATUS_EN
      slv.slv_datard_o = {ovf_q, 2'b00, 5'(count)};
`else
      slv.slv_datard_o = 8'h00;
`endif
    end else begin
      slv.slv_datard_o = {full, opm_status_i[6:0]};
    end
  end

endmodule

// File: tb/tb_opm_write_queue.sv
`timescale 1ns/1ps
module tb_opm_write_queue;

  localparam int STROBE = 14;
  localparam int PERIOD = 43;
`ifdef OPM_WRQ_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef struct {
    logic       a0;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       opm_cs_n, opm_wr_n, opm_a0;
  logic [7:0] opm_d;
  logic [7:0] opm_status = 8'h00;

  opm_write_queue_if bus ();

  opm_write_queue dut (
    .clk          (clk),
    .reset        (reset),
    .slv          (bus),
    .opm_cs_n     (opm_cs_n),
    .opm_wr_n     (opm_wr_n),
    .opm_a0       (opm_a0),
    .opm_d        (opm_d),
    .opm_status_i (opm_status)
  );

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   starts[$];
  int   strobe_cnt = 0;
  bit   in_strobe = 0;
  bit   abort_ok = 0;
  bit   shape_bad = 0;
  int   len = 0;
  logic sa0;
  logic [7:0] sd;

  initial begin
    bus.slv_addr_i       = '0;
    bus.slv_datawr_i     = '0;
    bus.slv_datawr_valid = 1'b0;
    bus.slv_req_i        = 1'b0;
    bus.slv_rwn_i        = 1'b1;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // OPM bus monitor: scoreboard pop at strobe start, shape check at strobe end.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (opm_cs_n !== opm_wr_n) shape_bad = 1;
    if (opm_cs_n === 1'b0) begin
      if (!in_strobe) begin
        in_strobe = 1;
        len = 0;
        shape_bad = 0;
        sa0 = opm_a0;
        sd = opm_d;
        strobe_cnt++;
        starts.push_back(cyc);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL strobe_unexpected: got a0=%0d d=%02h, nothing queued", opm_a0, opm_d);
        end else begin
          e = exp_q.pop_front();
          if ({opm_a0, opm_d} !== {e.a0, e.d}) begin
            fails++;
            $display("FAIL strobe_entry: got a0=%0d d=%02h, want a0=%0d d=%02h",
                     opm_a0, opm_d, e.a0, e.d);
          end
        end
      end
      if (opm_a0 !== sa0 || opm_d !== sd) shape_bad = 1;
      len++;
    end else if (in_strobe) begin
      in_strobe = 0;
      if (!abort_ok) begin
        tests++;
        if (len != STROBE || shape_bad) begin
          fails++;
          $display("FAIL strobe_shape: got len=%0d bad=%0d, want len=%0d bad=0",
                   len, shape_bad, STROBE);
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic host_write(input logic [4:0] addr, input logic [7:0] data,
                            input int hold, input bit push_exp);
    @(negedge clk);
    bus.slv_addr_i       = addr;
    bus.slv_datawr_i     = data;
    bus.slv_rwn_i        = 1'b0;
    bus.slv_req_i        = 1'b1;
    bus.slv_datawr_valid = 1'b1;
    if (push_exp) exp_q.push_back('{a0: addr[0], d: data});
    repeat (hold) @(negedge clk);
    bus.slv_req_i        = 1'b0;
    bus.slv_datawr_valid = 1'b0;
    bus.slv_rwn_i        = 1'b1;
  endtask

  task automatic host_read(input logic [4:0] addr, output logic [7:0] data);
    bus.slv_addr_i = addr;
    bus.slv_rwn_i  = 1'b1;
    bus.slv_req_i  = 1'b1;
    #1;
    data = bus.slv_datard_o;
    bus.slv_req_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || in_strobe) && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || in_strobe) begin
      fails++;
      $display("FAIL %s_drain: %0d entries still pending after %0d cycles, want 0",
               name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    opm_status = 8'h03;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({opm_cs_n, opm_wr_n, opm_a0, opm_d} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL reset_outputs: got cs=%b wr=%b a0=%b d=%02h, want 1 1 0 00",
               opm_cs_n, opm_wr_n, opm_a0, opm_d);
    end
    host_read(5'd0, rd);
    tests++;
    if (rd !== 8'h03) begin
      fails++;
      $display("FAIL reset_status_read: got %02h, want 03", rd);
    end
    host_read(5'd2, rd);
    tests++;
    if (rd !== 8'h00) begin
      fails++;
      $display("FAIL reset_ext_read: got %02h, want 00", rd);
    end
  endtask

  task automatic test_basic();
    int t0;
    starts.delete();
    @(negedge clk);
    bus.slv_addr_i       = 5'd0;
    bus.slv_datawr_i     = 8'h28;
    bus.slv_rwn_i        = 1'b0;
    bus.slv_req_i        = 1'b1;
    bus.slv_datawr_valid = 1'b1;
    exp_q.push_back('{a0: 1'b0, d: 8'h28});
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    bus.slv_req_i        = 1'b0;
    bus.slv_datawr_valid = 1'b0;
    bus.slv_rwn_i        = 1'b1;
    host_write(5'd1, 8'h4A, 1, 1);
    wait_drain(200, "basic");
    tests++;
    if (starts.size() != 2) begin
      fails++;
      $display("FAIL basic_strobe_count: got %0d, want 2", starts.size());
    end else begin
      tests++;
      if (starts[0] != t0 + 1) begin
        fails++;
        $display("FAIL basic_latency: strobe at cycle %0d, want %0d", starts[0], t0 + 1);
      end
      tests++;
      if (starts[1] - starts[0] != PERIOD) begin
        fails++;
        $display("FAIL basic_period: got %0d cycles, want %0d", starts[1] - starts[0], PERIOD);
      end
    end
  endtask

  task automatic test_fill_busy();
    logic [7:0] rd;
    int n0;
    opm_status = 8'h83;
    for (int i = 0; i < 16; i++) begin
      logic [4:0] a;
      a = {4'b0, i[0]};
      host_write(a, 8'hA0 + 8'(i), 1, 1);
    end
    n0 = strobe_cnt;
    repeat (50) @(negedge clk);
    tests++;
    if (strobe_cnt != n0) begin
      fails++;
      $display("FAIL busy_hold: got %0d strobes while busy, want 0", strobe_cnt - n0);
    end
    host_read(5'd0, rd);
    tests++;
    if (rd !== 8'h83) begin
      fails++;
      $display("FAIL full_status_read: got %02h, want 83", rd);
    end
    host_write(5'd0, 8'h55, 1, 0);
    @(negedge clk);
    host_read(5'd2, rd);
    tests++;
    if (rd !== (STATUS_EN ? 8'h90 : 8'h00)) begin
      fails++;
      $display("FAIL ovf_read: got %02h, want %02h", rd, STATUS_EN ? 8'h90 : 8'h00);
    end
    host_write(5'd2, 8'h00, 1, 0);
    @(negedge clk);
    host_read(5'd2, rd);
    tests++;
    if (rd !== (STATUS_EN ? 8'h10 : 8'h00)) begin
      fails++;
      $display("FAIL ovf_clear: got %02h, want %02h", rd, STATUS_EN ? 8'h10 : 8'h00);
    end
  endtask

  task automatic test_full_same_cycle();
    logic [7:0] rd;
    @(negedge clk);
    opm_status           = 8'h00;
    bus.slv_addr_i       = 5'd1;
    bus.slv_datawr_i     = 8'h77;
    bus.slv_rwn_i        = 1'b0;
    bus.slv_req_i        = 1'b1;
    bus.slv_datawr_valid = 1'b1;
    exp_q.push_back('{a0: 1'b1, d: 8'h77});
    @(posedge clk);
    #1;
    bus.slv_req_i        = 1'b0;
    bus.slv_datawr_valid = 1'b0;
    bus.slv_rwn_i        = 1'b1;
    host_read(5'd0, rd);
    tests++;
    if (rd !== 8'h80) begin
      fails++;
      $display("FAIL same_cycle_full: got %02h, want 80", rd);
    end
    host_read(5'd2, rd);
    tests++;
    if (rd !== (STATUS_EN ? 8'h10 : 8'h00)) begin
      fails++;
      $display("FAIL same_cycle_count: got %02h, want %02h", rd, STATUS_EN ? 8'h10 : 8'h00);
    end
    wait_drain(2000, "fill");
    host_read(5'd0, rd);
    tests++;
    if (rd !== 8'h00) begin
      fails++;
      $display("FAIL drained_status_read: got %02h, want 00", rd);
    end
  endtask

  task automatic test_hold_valid();
    int n0;
    n0 = strobe_cnt;
    host_write(5'd0, 8'h3C, 5, 1);
    wait_drain(200, "hold");
    repeat (100) @(negedge clk);
    tests++;
    if (strobe_cnt != n0 + 1) begin
      fails++;
      $display("FAIL hold_single_entry: got %0d strobes, want 1", strobe_cnt - n0);
    end
  endtask

  task automatic test_reset_strobe();
    logic [7:0] rd;
    int n;
    host_write(5'd0, 8'h11, 1, 1);
    host_write(5'd1, 8'h22, 1, 1);
    host_write(5'd0, 8'h33, 1, 1);
    n = 0;
    while (opm_cs_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (opm_cs_n !== 1'b0) begin
      fails++;
      $display("FAIL rst_strobe_start: cs_n=%b after %0d cycles, want 0", opm_cs_n, n);
    end
    repeat (3) @(negedge clk);
    abort_ok = 1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    tests++;
    if ({opm_cs_n, opm_wr_n, opm_a0, opm_d} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL rst_mid_strobe: got cs=%b wr=%b a0=%b d=%02h, want 1 1 0 00",
               opm_cs_n, opm_wr_n, opm_a0, opm_d);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    abort_ok = 0;
    n = strobe_cnt;
    repeat (150) @(negedge clk);
    tests++;
    if (strobe_cnt != n) begin
      fails++;
      $display("FAIL rst_queue_empty: got %0d strobes after reset, want 0", strobe_cnt - n);
    end
    host_read(5'd2, rd);
    tests++;
    if (rd !== 8'h00) begin
      fails++;
      $display("FAIL rst_ext_read: got %02h, want 00", rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_busy();
    test_full_same_cycle();
    test_hold_valid();
    test_reset_strobe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
